// File: rtl/nioshello_onchip_memory_master.sv
// nioshello_onchip_memory_master: Avalon-MM engine for bulk fill, copy and checksum over the on-chip RAM
module nioshello_onchip_memory_master #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 17
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                done,
    output logic [DATA_W-1:0]   result,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    input  logic [DATA_W-1:0]   readdata
);
    typedef enum logic [2:0] {IDLE, FILL, CP_RD, CP_CAP, CP_WR, SUM_RD, SUM_DRAIN, DONE} state_t;
    localparam logic [1:0] OP_INC = 2'd1, OP_COPY = 2'd2, OP_SUM = 2'd3;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [DATA_W-1:0] DATA_ONE = 1;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d, src_q, src_d, dst_q, dst_d;
    logic [DATA_W-1:0] writedata_q, writedata_d, acc_q, acc_d, result_q, result_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic chipselect_q, chipselect_d, write_q, write_d, done_q, done_d, ready_q, ready_d, inc_q, inc_d;
    logic accept, last;
    assign accept = cmd_valid & ready_q;
    assign last = (cnt_q + LEN_ONE) == len_q;
    assign cmd_ready = ready_q;
    assign done = done_q;
    assign result = result_q;
    assign address = address_q;
    assign byteenable = '1;
    assign chipselect = chipselect_q;
    assign write = write_q;
    assign writedata = writedata_q;
    // State and all registered outputs; reset leaves the bus idle with no done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            writedata_q  <= '0;
            acc_q        <= '0;
            result_q     <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            chipselect_q <= 1'b0;
            write_q      <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b0;
            inc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            writedata_q  <= writedata_d;
            acc_q        <= acc_d;
            result_q     <= result_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            chipselect_q <= chipselect_d;
            write_q      <= write_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
            inc_q        <= inc_d;
        end
    end
    // Next state: one bus state per cycle, zero-length commands go straight to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = (cmd_len == '0) ? DONE : (cmd_op == OP_COPY) ? CP_RD : (cmd_op == OP_SUM) ? SUM_RD : FILL;
            FILL:      if (last) state_d = DONE;
            CP_RD:     state_d = CP_CAP;
            CP_CAP:    state_d = CP_WR;
            CP_WR:     state_d = last ? DONE : CP_RD;
            SUM_RD:    if (last) state_d = SUM_DRAIN;
            SUM_DRAIN: state_d = DONE;
            default:   state_d = IDLE;
        endcase
    end
    // Next bus/datapath values; bus strobes follow the state being entered so they line up with it
    always_comb begin
        address_d    = address_q;
        src_d        = src_q;
        dst_d        = dst_q;
        writedata_d  = writedata_q;
        acc_d        = acc_q;
        result_d     = result_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        inc_d        = inc_q;
        chipselect_d = state_d inside {FILL, CP_RD, CP_WR, SUM_RD};
        write_d      = state_d inside {FILL, CP_WR};
        done_d       = state_d == DONE;
        ready_d      = state_d == IDLE;
        case (state_q)
            IDLE: if (accept) begin
                src_d       = cmd_src;
                dst_d       = cmd_dst;
                len_d       = cmd_len;
                cnt_d       = '0;
                inc_d       = cmd_op == OP_INC;
                acc_d       = '0;
                result_d    = '0;
                address_d   = (cmd_op == OP_COPY || cmd_op == OP_SUM) ? cmd_src : cmd_dst;
                writedata_d = cmd_data;
            end
            FILL: begin
                cnt_d       = cnt_q + LEN_ONE;
                address_d   = address_q + ADDR_ONE;
                writedata_d = inc_q ? writedata_q + DATA_ONE : writedata_q;
                if (last) result_d = DATA_W'(cnt_d);
            end
            CP_CAP: begin
                address_d   = dst_q;
                writedata_d = readdata;
            end
            CP_WR: begin
                cnt_d     = cnt_q + LEN_ONE;
                src_d     = src_q + ADDR_ONE;
                dst_d     = dst_q + ADDR_ONE;
                address_d = src_q + ADDR_ONE;
                if (last) result_d = DATA_W'(cnt_d);
            end
            SUM_RD: begin
                cnt_d     = cnt_q + LEN_ONE;
                address_d = address_q + ADDR_ONE;
                if (cnt_q != '0) acc_d = acc_q + readdata;
            end
            SUM_DRAIN: begin
                acc_d    = acc_q + readdata;
                result_d = acc_d;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_nioshello_onchip_memory_master.sv
// tb_nioshello_onchip_memory_master: directed checks of fill, copy, sum, wrap, zero length and mid-op reset
module tb_nioshello_onchip_memory_master;
    logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
    logic cmd_ready, done, chipselect, write;
    logic [1:0] cmd_op = 2'd0;
    logic [15:0] cmd_src = 16'h0, cmd_dst = 16'h0, address;
    logic [16:0] cmd_len = 17'h0;
    logic [31:0] cmd_data = 32'h0, result, writedata, readdata;
    logic [3:0] byteenable;
    logic [31:0] mem [0:65535];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    nioshello_onchip_memory_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .cmd_data(cmd_data), .done(done), .result(result), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(readdata)
    );

    // RAM model: write on the edge, read data valid the cycle after a read
    always @(posedge clk) begin
        if (chipselect && write) mem[address] <= writedata;
        readdata <= (chipselect && !write) ? mem[address] : 32'hDEAD_0BAD;
    end

    function automatic logic [63:0] bus();
        return {13'b0, done, chipselect, write, address, writedata};
    endfunction
    function automatic logic [63:0] wr_exp(input logic [15:0] a, input logic [31:0] d);
        return {13'b0, 1'b0, 1'b1, 1'b1, a, d};
    endfunction
    function automatic logic [63:0] rd_obs();
        return {45'b0, done, chipselect, write, address};
    endfunction
    function automatic logic [63:0] rd_exp(input logic [15:0] a);
        return {45'b0, 1'b0, 1'b1, 1'b0, a};
    endfunction
    function automatic logic [63:0] ctl();
        return {60'b0, cmd_ready, done, chipselect, write};
    endfunction
    function automatic logic [63:0] w32(input logic [31:0] v);
        return {32'b0, v};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] src, input logic [15:0] dst,
                         input logic [16:0] len, input logic [31:0] data);
        check("ready_before_cmd", ctl(), 64'h8);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_src = src;
        cmd_dst = dst;
        cmd_len = len;
        cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = ~op;
        cmd_src = ~src;
        cmd_dst = ~dst;
        cmd_len = 17'h5;
        cmd_data = ~data;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_ctl", ctl(), 64'h0);
        check("reset_bus", bus(), 64'h0);
        check("reset_result", w32(result), 64'h0);
        check("reset_byteenable", {60'b0, byteenable}, 64'hF);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", ctl(), 64'h8);

        issue(2'd1, 16'h0, 16'h0010, 17'd4, 32'hA000_0000);
        for (int i = 0; i < 4; i++) begin
            check("finc_write", bus(), wr_exp(16'(16'h0010 + i), 32'(32'hA000_0000 + i)));
            @(negedge clk);
        end
        check("finc_done", ctl(), 64'h4);
        check("finc_result", w32(result), 64'd4);
        @(negedge clk);
        check("finc_idle", ctl(), 64'h8);
        for (int i = 0; i < 4; i++) check("finc_mem", w32(mem[16'(16'h0010 + i)]), w32(32'(32'hA000_0000 + i)));

        issue(2'd2, 16'h0010, 16'h0100, 17'd4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("copy_read", rd_obs(), rd_exp(16'(16'h0010 + i)));
            @(negedge clk);
            check("copy_cap_idle", ctl(), 64'h0);
            if (i == 1) cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
            check("copy_write", bus(), wr_exp(16'(16'h0100 + i), 32'(32'hA000_0000 + i)));
            @(negedge clk);
        end
        check("copy_done", ctl(), 64'h4);
        check("copy_result", w32(result), 64'd4);
        @(negedge clk);
        check("copy_idle", ctl(), 64'h8);
        for (int i = 0; i < 4; i++) check("copy_mem", w32(mem[16'(16'h0100 + i)]), w32(32'(32'hA000_0000 + i)));

        issue(2'd3, 16'h0010, 16'h0, 17'd4, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("sum_read", rd_obs(), rd_exp(16'(16'h0010 + i)));
            @(negedge clk);
        end
        check("sum_drain", ctl(), 64'h0);
        @(negedge clk);
        check("sum_done", ctl(), 64'h4);
        check("sum_result", w32(result), w32(32'h8000_0006));
        @(negedge clk);
        check("sum_idle", ctl(), 64'h8);

        issue(2'd0, 16'h0, 16'hFFFE, 17'd4, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            check("wrap_write", bus(), wr_exp(16'(16'hFFFE + i), 32'h1234_5678));
            @(negedge clk);
        end
        check("wrap_done", ctl(), 64'h4);
        check("wrap_result", w32(result), 64'd4);
        @(negedge clk);
        check("wrap_mem_ffff", w32(mem[16'hFFFF]), w32(32'h1234_5678));
        check("wrap_mem_0001", w32(mem[16'h0001]), w32(32'h1234_5678));

        issue(2'd1, 16'h0, 16'h0050, 17'd0, 32'hFFFF_FFFF);
        check("len0_done", ctl(), 64'h4);
        check("len0_result", w32(result), 64'd0);
        @(negedge clk);
        check("len0_idle", ctl(), 64'h8);
        check("len0_mem", w32(mem[16'h0050]), 64'd0);

        issue(2'd2, 16'h0010, 16'h0200, 17'd4, 32'h0);
        repeat (8) @(negedge clk);
        check("rst_copy_word2_write", bus(), wr_exp(16'h0202, 32'hA000_0002));
        reset = 1'b1;
        @(negedge clk);
        check("rst_bus_idle", ctl(), 64'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", ctl(), 64'h8);
        end
        check("rst_mem_202", w32(mem[16'h0202]), w32(32'hA000_0002));
        check("rst_mem_203", w32(mem[16'h0203]), 64'd0);

        issue(2'd0, 16'h0, 16'h0300, 17'd2, 32'hDEAD_BEEF);
        for (int i = 0; i < 2; i++) begin
            check("post_rst_fill", bus(), wr_exp(16'(16'h0300 + i), 32'hDEAD_BEEF));
            @(negedge clk);
        end
        check("post_rst_done", ctl(), 64'h4);
        check("post_rst_result", w32(result), 64'd2);
        @(negedge clk);
        check("post_rst_mem", w32(mem[16'h0301]), w32(32'hDEAD_BEEF));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nioshello_onchip_memory_master.md
# niosHello_onchip_memory_master

Avalon-MM master engine that drives the slave port of the niosHello on-chip RAM (32-bit data, 16-bit word address, byte enables, fixed read latency 1, no waitrequest). It accepts one command at a time from a control interface (FILL, FILL_INC, COPY, SUM), sequences the memory accesses, and reports completion with a done pulse and a 32-bit result. It sits beside the Nios II data master on the RAM's interconnect for bulk initialisation, block copy and checksum without CPU involvement.

## Interface
Parameters:
- ADDR_W, 16, word-address width; matches the RAM's 65536-word depth.
- DATA_W, 32, data width; byte enables are DATA_W/8.
- LEN_W, 17, length width; allows 0..65536 words.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready at a rising edge.
- cmd_op  in  2  00 FILL, 01 FILL_INC, 10 COPY, 11 SUM.
- cmd_src  in  ADDR_W  source word address (COPY, SUM).
- cmd_dst  in  ADDR_W  destination word address (FILL, FILL_INC, COPY).
- cmd_len  in  LEN_W  number of words.
- cmd_data  in  DATA_W  fill pattern / base value.
- done  out  1  one-cycle pulse at completion.
- result  out  DATA_W  SUM: checksum; other ops: words written. Held until next accepted command.
- address  out  ADDR_W  to RAM address.
- byteenable  out  DATA_W/8  to RAM; all-ones on every access.
- chipselect  out  1  to RAM.
- write  out  1  to RAM; never high while chipselect is low.
- writedata  out  DATA_W  to RAM.
- readdata  in  DATA_W  from RAM; valid the cycle after a read cycle.

## Operation
- All command fields are latched on acceptance; later changes to cmd_* are ignored. cmd_valid while busy is ignored (not queued).
- States: IDLE, FILL, CP_RD, CP_CAP, CP_WR, SUM_RD, SUM_DRAIN, DONE.
- FILL / FILL_INC: word i (0..len-1) written to dst+i; data = cmd_data (FILL) or cmd_data+i mod 2^32 (FILL_INC). One write per cycle.
- COPY: per word i: read cycle at src+i (CP_RD), idle bus cycle capturing readdata into a register (CP_CAP), write cycle at dst+i with captured data (CP_WR). Ascending order, word by word; overlapping regions therefore follow forward-copy semantics (dst > src overlap propagates data; defined, not an error).
- SUM: reads src..src+len-1 on consecutive cycles; each readdata added to a 32-bit accumulator the cycle it is valid; sum mod 2^32. SUM_DRAIN absorbs the final read's data.
- All address arithmetic mod 2^ADDR_W (0xFFFF+1 = 0x0000).
- len = 0: no bus activity; straight to DONE, result = 0.
- DONE: done = 1 for one cycle, result updated, return to IDLE (cmd_ready high the following cycle).

## Timing
- All bus outputs and done/result registered. Cycle 1 = first cycle after the accepting edge.
- FILL/FILL_INC: writes in cycles 1..len; done in cycle len+1.
- COPY: word i read in cycle 3i+1, write in cycle 3i+3; done in cycle 3·len+1.
- SUM: reads in cycles 1..len; data accumulated cycles 2..len+1; done in cycle len+2.
- len = 0: done in cycle 1.
- Idle bus (IDLE, CP_CAP, SUM_DRAIN, DONE): chipselect = 0, write = 0.
- Reset values: cmd_ready = 1 (after first clock of reset deasserted: 1; during reset: 0), done = 0, result = 0, chipselect = 0, write = 0, address = 0, writedata = 0, byteenable = all-ones, accumulator = 0.
- Reset mid-operation: at the next edge the bus is idle, state IDLE, no done pulse; partially written memory is left as is.

## Test plan
- Reset: hold reset 3 cycles mid-idle -> all outputs at reset values; cmd_ready = 1 the cycle after release.
- FILL_INC dst=0x0010 len=4 data=0xA000_0000 -> writes 0x10..0x13 = 0xA000_0000..0xA000_0003 in cycles 1-4, done cycle 5, result = 4.
- COPY src=0x0010 dst=0x0100 len=4 against RAM model -> 0x100..0x103 match source, reads/writes every 3 cycles, done cycle 13, result = 4; cmd_valid pulsed mid-copy is ignored.
- SUM src=0x0010 len=4 over the filled words -> result = 0x8000_0006, done cycle 6.
- Wrap: FILL dst=0xFFFE len=4 data=0x1234_5678 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; len=0 command -> done cycle 1, result 0, chipselect never high.
- Reset asserted during COPY word 2 CP_WR -> chipselect/write low next cycle, no done; a subsequent FILL executes normally.
